// File: rtl/regfile_port_scheduler.sv
// Arbitrates the register file's single write and read ports among ALU writeback,
// load writeback and the MOV unit, running each MOV as a read-then-write sequence.

module regfile_port_scheduler #(
  parameter int RegisterSize = 32,
  parameter int AddrBits     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [AddrBits-1:0]     alu_reg,
  input  logic [RegisterSize-1:0] alu_value,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [AddrBits-1:0]     mem_reg,
  input  logic [RegisterSize-1:0] mem_value,
  input  logic                    mov_valid,
  output logic                    mov_ready,
  input  logic [AddrBits-1:0]     mov_origin,
  input  logic [AddrBits-1:0]     mov_destiny,
  output logic [AddrBits-1:0]     rf_readRegister,
  input  logic [RegisterSize-1:0] rf_readValue,
  output logic                    rf_writeEnable,
  output logic [AddrBits-1:0]     rf_writeRegister,
  output logic [RegisterSize-1:0] rf_writeValue,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOV_READ  = 2'd1,
    MOV_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
  localparam logic [1:0] SRC_MOV = 2'd2;

  state_t                  state_r, state_s;
  logic [1:0]              ptr_r, ptr_s;
  logic                    grant_en_s;
  logic [3:0]              valid_vec_s;
  logic [1:0]              cand1_s, cand2_s;
  logic                    grant_any_s;
  logic [1:0]              grant_src_s;
  logic                    we_r;
  logic [AddrBits-1:0]     wreg_r;
  logic [RegisterSize-1:0] wval_r;
  logic [AddrBits-1:0]     rreg_r;
  logic [AddrBits-1:0]     mov_dst_r;

  function automatic logic [1:0] next_src(input logic [1:0] src);
    case (src)
      SRC_ALU: next_src = SRC_MEM;
      SRC_MEM: next_src = SRC_MOV;
      default: next_src = SRC_ALU;
    endcase
  endfunction

  // Round-robin search starting at the pointer; reset and MOV_READ block every grant.
  always_comb begin
    grant_en_s  = reset && (state_r != MOV_READ);
    valid_vec_s = grant_en_s ? {1'b0, mov_valid, mem_valid, alu_valid} : 4'd0;
    cand1_s     = next_src(ptr_r);
    cand2_s     = next_src(cand1_s);
    grant_any_s = 1'b0;
    grant_src_s = ptr_r;
    if (valid_vec_s[ptr_r]) begin
      grant_any_s = 1'b1;
      grant_src_s = ptr_r;
    end else if (valid_vec_s[cand1_s]) begin
      grant_any_s = 1'b1;
      grant_src_s = cand1_s;
    end else if (valid_vec_s[cand2_s]) begin
      grant_any_s = 1'b1;
      grant_src_s = cand2_s;
    end else begin
      grant_any_s = 1'b0;
      grant_src_s = ptr_r;
    end
  end

  assign alu_ready = grant_any_s && (grant_src_s == SRC_ALU);
  assign mem_ready = grant_any_s && (grant_src_s == SRC_MEM);
  assign mov_ready = grant_any_s && (grant_src_s == SRC_MOV);

  // Next-state and pointer update.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    if (grant_any_s) begin
      ptr_s = next_src(grant_src_s);
    end else begin
      ptr_s = ptr_r;
    end
    case (state_r)
      IDLE, MOV_WRITE: begin
        if (mov_ready) begin
          state_s = MOV_READ;
        end else begin
          state_s = IDLE;
        end
      end
      MOV_READ: state_s = MOV_WRITE;
      default:  state_s = IDLE;
    endcase
  end

  // State and arbitration pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      ptr_r   <= SRC_ALU;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
    end
  end

  // Register-file port drivers; a MOV grant latches its indices for the read/write pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_r      <= 1'b0;
      wreg_r    <= '0;
      wval_r    <= '0;
      rreg_r    <= '0;
      mov_dst_r <= '0;
    end else begin
      case (state_r)
        MOV_READ: begin
          we_r   <= 1'b1;
          wreg_r <= mov_dst_r;
          wval_r <= rf_readValue;
        end
        default: begin
          if (alu_ready) begin
            we_r   <= 1'b1;
            wreg_r <= alu_reg;
            wval_r <= alu_value;
          end else if (mem_ready) begin
            we_r   <= 1'b1;
            wreg_r <= mem_reg;
            wval_r <= mem_value;
          end else if (mov_ready) begin
            we_r      <= 1'b0;
            rreg_r    <= mov_origin;
            mov_dst_r <= mov_destiny;
          end else begin
            we_r <= 1'b0;
          end
        end
      endcase
    end
  end

  assign rf_writeEnable   = we_r;
  assign rf_writeRegister = wreg_r;
  assign rf_writeValue    = wval_r;
  assign rf_readRegister  = rreg_r;
  assign busy             = (state_r == MOV_READ) || we_r;

  regfile_port_scheduler_checker u_checker (
    .clk            (clk),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_ready      (alu_ready),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mov_valid      (mov_valid),
    .mov_ready      (mov_ready),
    .in_mov_read    (state_r == MOV_READ),
    .rf_writeEnable (we_r),
    .busy           (busy)
  );

endmodule

// Handshake invariants of the scheduler.
module regfile_port_scheduler_checker (
  input logic clk,
  input logic reset,
  input logic alu_valid,
  input logic alu_ready,
  input logic mem_valid,
  input logic mem_ready,
  input logic mov_valid,
  input logic mov_ready,
  input logic in_mov_read,
  input logic rf_writeEnable,
  input logic busy
);

  a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({alu_ready, mem_ready, mov_ready}));
  a_alu_ready_valid: assert property (@(posedge clk) disable iff (!reset)
    alu_ready |-> alu_valid);
  a_mem_ready_valid: assert property (@(posedge clk) disable iff (!reset)
    mem_ready |-> mem_valid);
  a_mov_ready_valid: assert property (@(posedge clk) disable iff (!reset)
    mov_ready |-> mov_valid);
  a_no_grant_in_read: assert property (@(posedge clk) disable iff (!reset)
    in_mov_read |-> !(alu_ready || mem_ready || mov_ready));
  a_busy_def: assert property (@(posedge clk) disable iff (!reset)
    busy == (in_mov_read || rf_writeEnable));

endmodule

// File: tb/tb_regfile_port_scheduler.sv
// Directed bench for regfile_port_scheduler with a behavioural 16-entry register file.

module tb_regfile_port_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, mov_valid;
  logic        alu_ready, mem_ready, mov_ready;
  logic [3:0]  alu_reg, mem_reg, mov_origin, mov_destiny;
  logic [31:0] alu_value, mem_value;
  logic [3:0]  rf_readRegister, rf_writeRegister;
  logic [31:0] rf_readValue, rf_writeValue;
  logic        rf_writeEnable, busy;

  logic [31:0] rf [16];
  int          tests_run = 0;
  int          tests_failed = 0;

  always #5 clk = ~clk;

  regfile_port_scheduler dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_ready        (alu_ready),
    .alu_reg          (alu_reg),
    .alu_value        (alu_value),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_reg          (mem_reg),
    .mem_value        (mem_value),
    .mov_valid        (mov_valid),
    .mov_ready        (mov_ready),
    .mov_origin       (mov_origin),
    .mov_destiny      (mov_destiny),
    .rf_readRegister  (rf_readRegister),
    .rf_readValue     (rf_readValue),
    .rf_writeEnable   (rf_writeEnable),
    .rf_writeRegister (rf_writeRegister),
    .rf_writeValue    (rf_writeValue),
    .busy             (busy)
  );

  // Registers block: synchronous write, combinational read.
  always @(posedge clk) begin
    if (rf_writeEnable) rf[rf_writeRegister] <= rf_writeValue;
  end
  assign rf_readValue = rf[rf_readRegister];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    mov_valid = 1'b0;
  endtask

  logic [2:0]  exp_rdy  [8] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010, 3'b100, 3'b000};
  logic        exp_we   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  exp_wreg [8] = '{4'd0, 4'd10, 4'd11, 4'd0, 4'd12, 4'd10, 4'd11, 4'd0};

  initial begin
    reset = 1'b0;
    alu_valid = 1'b1; alu_reg = 4'd1; alu_value = 32'h1;
    mem_valid = 1'b1; mem_reg = 4'd1; mem_value = 32'h2;
    mov_valid = 1'b1; mov_origin = 4'd0; mov_destiny = 4'd0;
    #12;
    // Reset state with every requester asserting.
    check("rst_ready", {alu_ready, mem_ready, mov_ready}, 3'b000);
    check("rst_we", rf_writeEnable, 1'b0);
    check("rst_wreg", rf_writeRegister, 4'd0);
    check("rst_wval", rf_writeValue, 32'd0);
    check("rst_rreg", rf_readRegister, 4'd0);
    check("rst_busy", busy, 1'b0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;

    // ALU alone.
    next_cycle();
    alu_valid = 1'b1; alu_reg = 4'd3; alu_value = 32'hDEADBEEF;
    #1;
    check("t2_ready", {mov_ready, mem_ready, alu_ready}, 3'b001);
    next_cycle();
    idle_inputs();
    #1;
    check("t2_we", rf_writeEnable, 1'b1);
    check("t2_wreg", rf_writeRegister, 4'd3);
    check("t2_wval", rf_writeValue, 32'hDEADBEEF);
    next_cycle();
    check("t2_rf3", rf[3], 32'hDEADBEEF);
    check("t2_we_off", rf_writeEnable, 1'b0);

    // Load writes reg 2, then MOV 2->7 while the load write is in flight.
    mem_valid = 1'b1; mem_reg = 4'd2; mem_value = 32'h0000FFFF;
    #1;
    check("t4_mem_ready", {mov_ready, mem_ready, alu_ready}, 3'b010);
    next_cycle();
    mem_valid = 1'b0;
    mov_valid = 1'b1; mov_origin = 4'd2; mov_destiny = 4'd7;
    #1;
    check("t4_mem_wreg", rf_writeRegister, 4'd2);
    check("t4_mov_ready", {mov_ready, mem_ready, alu_ready}, 3'b100);
    next_cycle();
    mov_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 4'd1; alu_value = 32'h11111111;
    #1;
    check("t4_rreg", rf_readRegister, 4'd2);
    check("t4_read_we", rf_writeEnable, 1'b0);
    check("t4_read_busy", busy, 1'b1);
    check("t4_read_noalu", alu_ready, 1'b0);
    next_cycle();
    #1;
    check("t4_mov_we", rf_writeEnable, 1'b1);
    check("t4_mov_wreg", rf_writeRegister, 4'd7);
    check("t4_mov_wval", rf_writeValue, 32'h0000FFFF);
    check("t4_write_alu", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 1'b0;
    #1;
    check("t4_alu_wreg", rf_writeRegister, 4'd1);
    check("t4_alu_wval", rf_writeValue, 32'h11111111);
    check("t4_rf7", rf[7], 32'h0000FFFF);
    next_cycle();
    check("t4_idle_busy", busy, 1'b0);

    // ALU writes reg 5, MOV 5->9 granted the next cycle.
    alu_valid = 1'b1; alu_reg = 4'd5; alu_value = 32'h12345678;
    #1;
    check("t5_alu_ready", alu_ready, 1'b1);
    next_cycle();
    alu_valid = 1'b0;
    mov_valid = 1'b1; mov_origin = 4'd5; mov_destiny = 4'd9;
    #1;
    check("t5_mov_ready", mov_ready, 1'b1);
    next_cycle();
    mov_valid = 1'b0;
    next_cycle();
    check("t5_wreg", rf_writeRegister, 4'd9);
    check("t5_wval", rf_writeValue, 32'h12345678);
    next_cycle();
    check("t5_rf9", rf[9], 32'h12345678);

    // MOV onto itself.
    alu_valid = 1'b1; alu_reg = 4'd4; alu_value = 32'hA5A5A5A5;
    next_cycle();
    alu_valid = 1'b0;
    next_cycle();
    mov_valid = 1'b1; mov_origin = 4'd4; mov_destiny = 4'd4;
    #1;
    check("t6_ready", mov_ready, 1'b1);
    check("t6_busy_n", busy, 1'b0);
    next_cycle();
    mov_valid = 1'b0;
    check("t6_busy_n1", busy, 1'b1);
    check("t6_rreg", rf_readRegister, 4'd4);
    next_cycle();
    check("t6_busy_n2", busy, 1'b1);
    check("t6_wr", {rf_writeEnable, rf_writeRegister, rf_writeValue}, {1'b1, 4'd4, 32'hA5A5A5A5});
    next_cycle();
    check("t6_busy_n3", busy, 1'b0);

    // All three requesters held high.
    alu_valid = 1'b1; alu_reg = 4'd10; alu_value = 32'hAAAA0001;
    mem_valid = 1'b1; mem_reg = 4'd11; mem_value = 32'hBBBB0002;
    mov_valid = 1'b1; mov_origin = 4'd10; mov_destiny = 4'd12;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("t3_rdy%0d", i), {mov_ready, mem_ready, alu_ready}, exp_rdy[i]);
      check($sformatf("t3_we%0d", i), rf_writeEnable, exp_we[i]);
      if (exp_we[i]) check($sformatf("t3_wreg%0d", i), rf_writeRegister, exp_wreg[i]);
      if (i == 4) check("t3_movval", rf_writeValue, 32'hAAAA0001);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // Reset asserted while a MOV sits in MOV_READ.
    mov_valid = 1'b1; mov_origin = 4'd3; mov_destiny = 4'd8;
    #1;
    check("t1_mov_ready", mov_ready, 1'b1);
    next_cycle();
    mov_valid = 1'b0;
    alu_valid = 1'b1; alu_reg = 4'd6; alu_value = 32'h66666666;
    mem_valid = 1'b1;
    #1;
    check("t1_in_read", busy, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("t1_rst_we", rf_writeEnable, 1'b0);
    check("t1_rst_ready", {mov_ready, mem_ready, alu_ready}, 3'b000);
    check("t1_rst_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t1_first_grant", {mov_ready, mem_ready, alu_ready}, 3'b001);
    next_cycle();
    idle_inputs();
    check("t1_alu_write", {rf_writeEnable, rf_writeRegister, rf_writeValue}, {1'b1, 4'd6, 32'h66666666});
    next_cycle();
    check("t1_no_mov_write", rf_writeEnable, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
